biu_request_queue: RTL and testbench

- Upstream stage of the bus interface unit: buffers read/write requests from the core in a small FIFO.
- Issues each request to the BIU as a single-cycle read/write strobe, waits for the BIU ready, captures read data and returns a response pulse to the core.
- Adds a watchdog timeout so a missing ready cannot hang the core.

---
 rtl/biu_pkg.sv | 22 ++
 rtl/biu_req_fifo.sv | 67 ++++++
 rtl/biu_request_queue.sv | 147 ++++++++++++++
 tb/tb_biu_request_queue.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// Shared types for the BIU request path.
//   biu_cmd_t  : one queued request {we, addr, wdata} at the default widths
//   rq_state_t : request-queue sequencer states
package biu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } biu_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } rq_state_t;

endpackage

// File: rtl/biu_req_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
//   clk, reset        : clock, async active-high reset
//   push, push_data   : write port; accepted when not full, or when full and
//                       a pop happens in the same cycle
//   pop               : advance the head (ignored when empty)
//   head              : current head entry, combinational
//   empty, full       : status flags
//   level             : number of valid entries (0..DEPTH)
module biu_req_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_L = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to fill.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/biu_request_queue.sv
// Request queue in front of the bus interface unit.
// Buffers core requests, issues each one to the BIU as a single-cycle
// read/write strobe, waits for biu_ready (bounded by a watchdog), and
// returns a one-cycle response pulse to the core.
//   clk, reset                         : clock, async active-high reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                 : core request channel
//   rsp_valid/rsp_we/rsp_err/rsp_rdata : core response channel (no backpressure)
//   biu_read/biu_write/biu_addr/
//   biu_wdata/biu_ready/biu_rdata      : BIU side
//   level                              : request FIFO occupancy
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | pop the FIFO head into the command register when available
// ISSUE   | one-cycle read or write strobe to the BIU
// WAIT    | wait for biu_ready; watchdog aborts after TIMEOUT cycles
// CAPTURE | sample biu_rdata, response pulse follows next cycle
module biu_request_queue
    import biu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_we,
    output logic                   rsp_err,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   biu_read,
    output logic                   biu_write,
    output logic [ADDR_W-1:0]      biu_addr,
    output logic [DATA_W-1:0]      biu_wdata,
    input  logic                   biu_ready,
    input  logic [DATA_W-1:0]      biu_rdata,
    output logic [$clog2(DEPTH):0] level
);

    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    localparam int CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_L = TIMEOUT[CW-1:0];

    rq_state_t         state;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [CW-1:0]     wait_cnt;
    logic [CW-1:0]     wait_cnt_nxt;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CMD_W-1:0]  fifo_head;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    biu_req_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({req_we, req_addr, req_wdata}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    // Strobes are decoded from ISSUE so they can never last beyond one cycle.
    assign biu_read     = (state == ISSUE) && !cmd_we;
    assign biu_write    = (state == ISSUE) && cmd_we;
    assign biu_addr     = cmd_addr;
    assign biu_wdata    = cmd_wdata;
    assign wait_cnt_nxt = wait_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_we    <= fifo_head[CMD_W-1];
                        cmd_addr  <= fifo_head[DATA_W +: ADDR_W];
                        cmd_wdata <= fifo_head[DATA_W-1:0];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A ready on the final watchdog cycle still completes normally.
                    if (biu_ready) begin
                        wait_cnt <= '0;
                        state    <= CAPTURE;
                    end else if (wait_cnt_nxt == TMO_L) begin
                        wait_cnt  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_we    <= cmd_we;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                    end
                end
                CAPTURE: begin
                    // biu_rdata is valid one cycle after biu_ready, i.e. now.
                    rsp_valid <= 1'b1;
                    rsp_we    <= cmd_we;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= cmd_we ? '0 : biu_rdata;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biu_request_queue.sv
module tb_biu_request_queue;
    import biu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;
    localparam int NEVER = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_we;
    logic       rsp_err;
    logic [7:0] rsp_rdata;
    logic       biu_read;
    logic       biu_write;
    logic [7:0] biu_addr;
    logic [7:0] biu_wdata;
    logic       biu_ready = 1'b0;
    logic [7:0] biu_rdata = '0;
    logic [2:0] level;

    always #5 clk = ~clk;

    biu_request_queue #(
        .ADDR_W (8),
        .DATA_W (8),
        .DEPTH  (DEPTH),
        .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_we    (rsp_we),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .biu_read  (biu_read),
        .biu_write (biu_write),
        .biu_addr  (biu_addr),
        .biu_wdata (biu_wdata),
        .biu_ready (biu_ready),
        .biu_rdata (biu_rdata),
        .level     (level)
    );

    typedef struct { biu_cmd_t cmd; int cyc; int lat; } strobe_t;
    typedef struct { logic we; logic err; logic [7:0] rdata; int cyc; } rsp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    biu_cmd_t req_q[$];
    strobe_t  strb_q[$];
    rsp_t     rsp_q[$];
    int       lat_plan[$];

    int         biu_mode = 0;      // 0: ready 1 cycle after strobe, 1: never, 2: random
    int         spurious_en = 0;
    logic [7:0] mem_biu [256];
    logic [7:0] ref_mem [256];
    int         strobe_viol = 0;
    int         stab_viol = 0;
    int         max_level = 0;

    logic       busy = 1'b0;
    logic       prev_strobe = 1'b0;
    logic       prev_ready = 1'b0;
    int         cd = 0;
    biu_cmd_t   cur;

    // BIU model and monitor share one process so their view of each cycle agrees.
    always @(negedge clk) begin
        int      lat;
        strobe_t s;
        rsp_t    r;
        cyc++;
        if (reset) begin
            busy        = 1'b0;
            prev_strobe = 1'b0;
            prev_ready  = 1'b0;
            cd          = 0;
            biu_ready   = 1'b0;
        end else begin
            if ((biu_read || biu_write) && prev_strobe) strobe_viol++;
            if ((biu_read && biu_write)) strobe_viol++;
            prev_strobe = biu_read || biu_write;
            if (int'(level) > max_level) max_level = int'(level);
            biu_rdata = prev_ready ? mem_biu[cur.addr] : 8'($urandom);
            prev_ready = 1'b0;
            if (busy && (biu_addr !== cur.addr || biu_wdata !== cur.wdata)) stab_viol++;
            if (rsp_valid) begin
                r.we = rsp_we; r.err = rsp_err; r.rdata = rsp_rdata; r.cyc = cyc;
                rsp_q.push_back(r);
                busy = 1'b0;
            end
            if (biu_read || biu_write) begin
                cur.we = biu_write; cur.addr = biu_addr; cur.wdata = biu_wdata;
                if (lat_plan.size() > 0) lat = lat_plan.pop_front();
                else if (biu_mode == 0) lat = 1;
                else if (biu_mode == 1) lat = NEVER;
                else begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4, 5: lat = int'($urandom_range(1, 4));
                        6:                lat = TMO;
                        7:                lat = TMO + 1;
                        default:          lat = int'($urandom_range(5, TMO + 3));
                    endcase
                end
                s.cmd = cur; s.cyc = cyc; s.lat = lat;
                strb_q.push_back(s);
                busy = 1'b1;
                cd = lat;
                biu_ready = (spurious_en != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (busy && cd > 0 && cd < NEVER) begin
                cd--;
                if (cd == 0) begin
                    biu_ready  = 1'b1;
                    prev_ready = 1'b1;
                    if (cur.we) mem_biu[cur.addr] = cur.wdata;
                end else begin
                    biu_ready = 1'b0;
                end
            end else if (busy) begin
                biu_ready = 1'b0;
            end else begin
                biu_ready = (spurious_en != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic clear_logs();
        req_q.delete(); strb_q.delete(); rsp_q.delete(); lat_plan.delete();
        strobe_viol = 0; stab_viol = 0; max_level = 0;
    endtask

    task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
        int w = 0;
        biu_cmd_t c;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL push_accept: req_ready stayed %0b, required 1", req_ready);
        end else begin
            c.we = we; c.addr = a; c.wdata = d;
            req_q.push_back(c);
        end
        @(posedge clk);
    endtask

    task automatic req_idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget, input string name);
        int w = 0;
        while (rsp_q.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (rsp_q.size() < n) begin
            errors++;
            $display("FAIL %s_wait: got %0d responses, required %0d", name, rsp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_we, rsp_err, rsp_rdata, biu_read, biu_write, biu_addr, biu_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {rsp_valid, rsp_we, rsp_err, rsp_rdata, biu_read, biu_write, biu_addr, biu_wdata});
        end
        checks++;
        if (req_ready !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("FAIL reset_fifo: req_ready=%b level=%0d, required 1 and 0", req_ready, level);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read();
        int st_at = -1, st_n = 0, wr_n = 0, rs_at = -1;
        logic we_s = 1'bx, err_s = 1'bx;
        logic [7:0] rd_s = 'x;
        clear_logs();
        biu_mode = 0; spurious_en = 0;
        mem_biu[8'h10] = 8'hA5;
        push(1'b0, 8'h10, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (biu_read) begin st_n++; st_at = k; end
            if (biu_write) wr_n++;
            if (rsp_valid && rs_at < 0) begin
                rs_at = k; we_s = rsp_we; err_s = rsp_err; rd_s = rsp_rdata;
            end
        end
        checks++;
        if (st_n != 1 || st_at != 2 || wr_n != 0) begin
            errors++;
            $display("FAIL single_strobe: read pulses=%0d at cycle %0d writes=%0d, required 1 at 2 and 0", st_n, st_at, wr_n);
        end
        checks++;
        if (rs_at != 5) begin
            errors++;
            $display("FAIL single_latency: rsp_valid at cycle %0d after push, required 5", rs_at);
        end
        checks++;
        if ({we_s, err_s, rd_s} !== {1'b0, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL single_rsp: we=%b err=%b rdata=%h, required 0 0 a5", we_s, err_s, rd_s);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: rsp_valid=%b rdata=%h, required 0 a5", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_write_read();
        clear_logs();
        biu_mode = 0; spurious_en = 0;
        push(1'b1, 8'h20, 8'h3C);
        push(1'b0, 8'h20, 8'h00);
        req_idle();
        wait_rsp(2, 100, "wr_rd");
        if (strb_q.size() >= 2 && rsp_q.size() >= 2) begin
            checks++;
            if (strb_q[0].cmd !== {1'b1, 8'h20, 8'h3C}) begin
                errors++;
                $display("FAIL wr_rd_wstrobe: got %h, required 1203c", strb_q[0].cmd);
            end
            checks++;
            if (strb_q[1].cmd.we !== 1'b0 || strb_q[1].cmd.addr !== 8'h20) begin
                errors++;
                $display("FAIL wr_rd_rstrobe: we=%b addr=%h, required 0 20", strb_q[1].cmd.we, strb_q[1].cmd.addr);
            end
            checks++;
            if ({rsp_q[0].we, rsp_q[0].err, rsp_q[0].rdata} !== {1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL wr_rd_wrsp: we=%b err=%b rdata=%h, required 1 0 00", rsp_q[0].we, rsp_q[0].err, rsp_q[0].rdata);
            end
            checks++;
            if ({rsp_q[1].we, rsp_q[1].err, rsp_q[1].rdata} !== {1'b0, 1'b0, 8'h3C}) begin
                errors++;
                $display("FAIL wr_rd_rrsp: we=%b err=%b rdata=%h, required 0 0 3c", rsp_q[1].we, rsp_q[1].err, rsp_q[1].rdata);
            end
        end
    endtask

    task automatic test_fill();
        clear_logs();
        biu_mode = 1; spurious_en = 0;
        for (int i = 0; i < 5; i++) push(1'(i % 2), 8'(8'h30 + i), 8'(8'h60 + i));
        req_idle();
        checks++;
        if (level !== 3'd4 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: level=%0d req_ready=%b, required 4 and 0", level, req_ready);
        end
        wait_rsp(5, 5 * (TMO + 4) + 50, "fill");
        repeat (20) @(negedge clk);
        checks++;
        if (rsp_q.size() != 5 || strb_q.size() != 5 || max_level != DEPTH) begin
            errors++;
            $display("FAIL fill_counts: rsp=%0d strobes=%0d max_level=%0d, required 5 5 4", rsp_q.size(), strb_q.size(), max_level);
        end
        for (int i = 0; i < 5 && i < rsp_q.size() && i < strb_q.size(); i++) begin
            checks++;
            if (strb_q[i].cmd !== req_q[i]) begin
                errors++;
                $display("FAIL fill_order[%0d]: strobe %h, required %h", i, strb_q[i].cmd, req_q[i]);
            end
            checks++;
            if ({rsp_q[i].we, rsp_q[i].err, rsp_q[i].rdata} !== {req_q[i].we, 1'b1, 8'h00}) begin
                errors++;
                $display("FAIL fill_rsp[%0d]: we=%b err=%b rdata=%h, required %b 1 00", i, rsp_q[i].we, rsp_q[i].err, rsp_q[i].rdata, req_q[i].we);
            end
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        biu_mode = 2; spurious_en = 0;
        lat_plan.push_back(NEVER);
        lat_plan.push_back(TMO);
        lat_plan.push_back(1);
        push(1'b0, 8'h50, 8'h00);
        push(1'b1, 8'h51, 8'hAB);
        push(1'b0, 8'h51, 8'h00);
        req_idle();
        wait_rsp(3, 3 * (TMO + 6) + 50, "timeout");
        if (rsp_q.size() >= 3 && strb_q.size() >= 3) begin
            checks++;
            if ({rsp_q[0].we, rsp_q[0].err, rsp_q[0].rdata} !== {1'b0, 1'b1, 8'h00}) begin
                errors++;
                $display("FAIL timeout_rsp: we=%b err=%b rdata=%h, required 0 1 00", rsp_q[0].we, rsp_q[0].err, rsp_q[0].rdata);
            end
            checks++;
            if (rsp_q[0].cyc - strb_q[0].cyc != TMO + 1) begin
                errors++;
                $display("FAIL timeout_cycles: strobe-to-rsp %0d, required %0d", rsp_q[0].cyc - strb_q[0].cyc, TMO + 1);
            end
            checks++;
            if (strb_q[1].cyc - rsp_q[0].cyc != 1) begin
                errors++;
                $display("FAIL timeout_next_issue: rsp-to-next-strobe %0d, required 1", strb_q[1].cyc - rsp_q[0].cyc);
            end
            checks++;
            if ({rsp_q[1].we, rsp_q[1].err} !== 2'b10 || rsp_q[1].cyc - strb_q[1].cyc != TMO + 2) begin
                errors++;
                $display("FAIL timeout_last_ready: we=%b err=%b delay=%0d, required 1 0 %0d", rsp_q[1].we, rsp_q[1].err, rsp_q[1].cyc - strb_q[1].cyc, TMO + 2);
            end
            checks++;
            if ({rsp_q[2].err, rsp_q[2].rdata} !== {1'b0, 8'hAB}) begin
                errors++;
                $display("FAIL timeout_readback: err=%b rdata=%h, required 0 ab", rsp_q[2].err, rsp_q[2].rdata);
            end
        end
    endtask

    task automatic test_push_pop_full();
        clear_logs();
        biu_mode = 0; spurious_en = 1;
        for (int i = 0; i < 12; i++) push(1'(i % 2 == 0), 8'(8'h80 + i / 2), 8'(8'h80 + i / 2));
        req_idle();
        wait_rsp(12, 12 * 6 + 50, "laps");
        checks++;
        if (max_level != DEPTH) begin
            errors++;
            $display("FAIL laps_level: max level %0d, required %0d", max_level, DEPTH);
        end
        for (int i = 0; i < 12 && i < rsp_q.size() && i < strb_q.size(); i++) begin
            checks++;
            if (strb_q[i].cmd !== req_q[i]) begin
                errors++;
                $display("FAIL laps_order[%0d]: strobe %h, required %h", i, strb_q[i].cmd, req_q[i]);
            end
            checks++;
            if (rsp_q[i].err !== 1'b0 || rsp_q[i].rdata !== (req_q[i].we ? 8'h00 : req_q[i].addr)) begin
                errors++;
                $display("FAIL laps_rsp[%0d]: err=%b rdata=%h, required 0 %h", i, rsp_q[i].err, rsp_q[i].rdata, req_q[i].we ? 8'h00 : req_q[i].addr);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        clear_logs();
        biu_mode = 1; spurious_en = 0;
        for (int i = 0; i < 3; i++) push(1'b1, 8'(8'hC0 + i), 8'(8'hD0 + i));
        req_idle();
        while (strb_q.size() < 1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (level !== 3'd2 || strb_q.size() != 1) begin
            errors++;
            $display("FAIL rstmid_pre: level=%0d strobes=%0d, required 2 1", level, strb_q.size());
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_we, rsp_err, rsp_rdata, biu_read, biu_write, biu_addr, biu_wdata, level} !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: outputs %h req_ready=%b, required 0 and 1",
                     {rsp_valid, rsp_we, rsp_err, rsp_rdata, biu_read, biu_write, biu_addr, biu_wdata, level}, req_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        repeat (40) @(negedge clk);
        checks++;
        if (rsp_q.size() != 0 || strb_q.size() != 0 || level !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_after: rsp=%0d strobes=%0d level=%0d, required 0 0 0", rsp_q.size(), strb_q.size(), level);
        end
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic       e_err;
        logic [7:0] e_rd;
        int         e_dly;
        clear_logs();
        biu_mode = 2; spurious_en = 1;
        for (int a = 0; a < 256; a++) begin
            mem_biu[a] = 8'(a) ^ 8'h5A;
            ref_mem[a] = 8'(a) ^ 8'h5A;
        end
        for (int i = 0; i < N; i++) begin
            push(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
        end
        req_idle();
        wait_rsp(N, N * (TMO + 8) + 100, "random");
        repeat (10) @(negedge clk);
        checks++;
        if (rsp_q.size() != N || strb_q.size() != N) begin
            errors++;
            $display("FAIL random_counts: rsp=%0d strobes=%0d, required %0d", rsp_q.size(), strb_q.size(), N);
        end
        for (int i = 0; i < N && i < rsp_q.size() && i < strb_q.size(); i++) begin
            e_err = (strb_q[i].lat > TMO);
            e_rd  = (req_q[i].we || e_err) ? 8'h00 : ref_mem[req_q[i].addr];
            e_dly = e_err ? TMO + 1 : strb_q[i].lat + 2;
            if (req_q[i].we && !e_err) ref_mem[req_q[i].addr] = req_q[i].wdata;
            checks++;
            if (strb_q[i].cmd !== req_q[i]) begin
                errors++;
                $display("FAIL random_strobe[%0d]: got %h, required %h", i, strb_q[i].cmd, req_q[i]);
            end
            checks++;
            if ({rsp_q[i].we, rsp_q[i].err, rsp_q[i].rdata} !== {req_q[i].we, e_err, e_rd}) begin
                errors++;
                $display("FAIL random_rsp[%0d]: we=%b err=%b rdata=%h, required %b %b %h (lat %0d)",
                         i, rsp_q[i].we, rsp_q[i].err, rsp_q[i].rdata, req_q[i].we, e_err, e_rd, strb_q[i].lat);
            end
            checks++;
            if (rsp_q[i].cyc - strb_q[i].cyc != e_dly) begin
                errors++;
                $display("FAIL random_delay[%0d]: strobe-to-rsp %0d, required %0d", i, rsp_q[i].cyc - strb_q[i].cyc, e_dly);
            end
        end
        checks++;
        if (strobe_viol != 0 || stab_viol != 0) begin
            errors++;
            $display("FAIL random_strobe_rules: held/double strobes=%0d addr/data changes=%0d, required 0 0", strobe_viol, stab_viol);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem_biu[a] = 8'(a);
        test_reset();
        test_single_read();
        test_write_read();
        test_fill();
        test_timeout();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
